// File: rtl/muldiv_hilo.sv
// muldiv_hilo: multi-cycle MULT/MULTU/DIV/DIVU/MTHI/MTLO unit owning HI/LO
//   clk, reset (async, active-high)
//   start/op/a/b : request, sampled only while idle; op 6/7 are ignored
//   flush        : abandons an in-flight operation without touching HI/LO
//   busy/done    : operation in progress / one-cycle pulse once HI/LO hold the result
//   hi/lo        : architectural HI/LO registers
module muldiv_hilo #(
    parameter int WIDTH    = 32,
    parameter int MUL_LAT  = 3,
    parameter int DIV_STEP = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             flush,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);
    localparam int DIV_ITER = WIDTH / DIV_STEP;
    localparam int CW = $clog2((MUL_LAT > DIV_ITER ? MUL_LAT : DIV_ITER) + 1);

    typedef enum logic [1:0] {IDLE, MUL, DIV, FIX} state_t;

    state_t             state, state_n;
    logic [CW-1:0]      cnt;
    logic [2*WIDTH-1:0] prod, a_ext, b_ext;
    logic [WIDTH-1:0]   rem, rem_n, quo, quo_n, dvs, sp_hi, sp_lo, a_abs, b_abs;
    logic [WIDTH:0]     t;
    logic               neg_q, neg_r, sp, acc, sgn, last, done_n;

    assign busy   = state != IDLE;
    assign acc    = start && !busy && !flush && !(op[2] && op[1]);
    assign sgn    = !op[0];
    assign last   = cnt == CW'(1);
    assign a_abs  = sgn && a[WIDTH-1] ? -a : a;
    assign b_abs  = sgn && b[WIDTH-1] ? -b : b;
    assign a_ext  = {{WIDTH{sgn & a[WIDTH-1]}}, a};
    assign b_ext  = {{WIDTH{sgn & b[WIDTH-1]}}, b};
    assign done_n = (acc && op[2]) || (!flush && ((state == MUL && last) || state == FIX));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_n;
    end

    always_comb begin
        state_n = state;
        case (state)
            IDLE:    state_n = !acc || op[2] ? IDLE : op[1] ? DIV : MUL;
            MUL:     state_n = last ? IDLE : MUL;
            DIV:     state_n = last ? FIX : DIV;
            default: state_n = IDLE;
        endcase
        if (busy && flush) state_n = IDLE;
    end

    // Restoring division, DIV_STEP quotient bits per cycle, MSB first.
    // The dividend is shifted out of quo while quotient bits are shifted in.
    always_comb begin
        rem_n = rem;
        quo_n = quo;
        t     = '0;
        for (int i = 0; i < DIV_STEP; i++) begin
            t     = {rem_n, quo_n[WIDTH-1]};
            quo_n = {quo_n[WIDTH-2:0], 1'b0};
            if (t >= {1'b0, dvs}) begin
                t        = t - {1'b0, dvs};
                quo_n[0] = 1'b1;
            end
            rem_n = t[WIDTH-1:0];
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            done  <= 1'b0;
            hi    <= '0;
            lo    <= '0;
            cnt   <= '0;
            prod  <= '0;
            rem   <= '0;
            quo   <= '0;
            dvs   <= '0;
            neg_q <= 1'b0;
            neg_r <= 1'b0;
            sp    <= 1'b0;
            sp_hi <= '0;
            sp_lo <= '0;
        end else begin
            done <= done_n;
            if (acc) begin
                if (op == 3'd4) hi <= a;
                if (op == 3'd5) lo <= a;
                cnt   <= op[1] ? CW'(DIV_ITER) : CW'(MUL_LAT);
                prod  <= a_ext * b_ext;
                rem   <= '0;
                quo   <= a_abs;
                dvs   <= b_abs;
                neg_q <= sgn && (a[WIDTH-1] ^ b[WIDTH-1]);
                neg_r <= sgn && a[WIDTH-1];
                // Divide-by-zero and signed overflow bypass the sign fix-up; the divider still runs its full length.
                sp    <= b == '0 || (sgn && a == {1'b1, {(WIDTH-1){1'b0}}} && b == '1);
                sp_hi <= b == '0 ? a : '0;
                sp_lo <= b == '0 ? '1 : a;
            end
            if (state == MUL || state == DIV) cnt <= cnt - CW'(1);
            if (state == DIV) begin
                rem <= rem_n;
                quo <= quo_n;
            end
            if (!flush && state == MUL && last) {hi, lo} <= prod;
            if (!flush && state == FIX) begin
                hi <= sp ? sp_hi : neg_r ? -rem : rem;
                lo <= sp ? sp_lo : neg_q ? -quo : quo;
            end
        end
    end
endmodule

// File: tb/tb_muldiv_hilo.sv
// tb_muldiv_hilo: directed self-checking bench for muldiv_hilo
module tb_muldiv_hilo;
    logic        clk = 0, reset = 1, start = 0, flush = 0;
    logic [2:0]  op = 0;
    logic [31:0] a = 0, b = 0;
    logic        busy, done, busy4, done4;
    logic [31:0] hi, lo, hi4, lo4;
    int          passed = 0, total = 0;
    int          d1, d4, bsy, nd;

    muldiv_hilo u_dut (
        .clk(clk), .reset(reset), .start(start), .op(op), .a(a), .b(b),
        .flush(flush), .busy(busy), .done(done), .hi(hi), .lo(lo)
    );

    muldiv_hilo #(.DIV_STEP(4)) u_dut4 (
        .clk(clk), .reset(reset), .start(start), .op(op), .a(a), .b(b),
        .flush(flush), .busy(busy4), .done(done4), .hi(hi4), .lo(lo4)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic issue(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y);
        @(negedge clk);
        start = 1; op = o; a = x; b = y;
        @(negedge clk);
        start = 0;
    endtask

    task automatic wait_done();
        d1 = 0; d4 = 0; bsy = 0;
        for (int n = 1; n <= 60; n++) begin
            if (done4 && d4 == 0) d4 = n;
            if (done) begin
                d1 = n;
                break;
            end
            if (busy) bsy++;
            @(negedge clk);
        end
        if (d1 == 0) check("done_timeout", 0, 1);
    endtask

    task automatic watch(input int n);
        nd = 0;
        repeat (n) begin
            @(negedge clk);
            nd += int'(done);
        end
    endtask

    initial begin
        @(negedge clk);
        check("rst_hi", hi, 0);
        check("rst_lo", lo, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        reset = 0;

        issue(3'd0, 32'hFFFFFFFF, 32'hFFFFFFFF);
        wait_done();
        check("mult_cycle", d1, 4);
        check("mult_busy", bsy, 3);
        check("mult_busy_in_done", busy, 0);
        check("mult_hi", hi, 32'h00000000);
        check("mult_lo", lo, 32'h00000001);

        issue(3'd1, 32'hFFFFFFFF, 32'hFFFFFFFF);
        wait_done();
        check("multu_hi", hi, 32'hFFFFFFFE);
        check("multu_lo", lo, 32'h00000001);
        start = 1; op = 3'd1; a = 3; b = 5;
        @(negedge clk);
        start = 0;
        check("b2b_busy", busy, 1);
        wait_done();
        check("b2b_hi", hi, 0);
        check("b2b_lo", lo, 15);

        issue(3'd2, 32'hFFFFFFF9, 32'd2);
        wait_done();
        check("div_cycle", d1, 34);
        check("div_busy", bsy, 33);
        check("div4_cycle", d4, 10);
        check("div_lo", lo, 32'hFFFFFFFD);
        check("div_hi", hi, 32'hFFFFFFFF);
        check("div4_lo", lo4, 32'hFFFFFFFD);
        check("div4_hi", hi4, 32'hFFFFFFFF);

        issue(3'd3, 32'd100, 32'd7);
        wait_done();
        check("divu_lo", lo, 14);
        check("divu_hi", hi, 2);

        issue(3'd3, 32'h1234, 32'd0);
        wait_done();
        check("div0_cycle", d1, 34);
        check("div0_lo", lo, 32'hFFFFFFFF);
        check("div0_hi", hi, 32'h1234);

        issue(3'd2, 32'h80000000, 32'hFFFFFFFF);
        wait_done();
        check("ovf_lo", lo, 32'h80000000);
        check("ovf_hi", hi, 0);

        issue(3'd2, 32'd7, 32'hFFFFFFFE);
        wait_done();
        check("div_pn_lo", lo, 32'hFFFFFFFD);
        check("div_pn_hi", hi, 1);

        issue(3'd2, 32'hFFFFFFF9, 32'hFFFFFFFE);
        wait_done();
        check("div_nn_lo", lo, 3);
        check("div_nn_hi", hi, 32'hFFFFFFFF);

        @(negedge clk);
        start = 1; op = 3'd4; a = 32'hA5A5A5A5;
        @(negedge clk);
        check("mthi_done", done, 1);
        check("mthi_busy", busy, 0);
        op = 3'd5; a = 32'h5A5A5A5A;
        @(negedge clk);
        start = 0;
        check("mtlo_done", done, 1);
        check("mtlo_busy", busy, 0);
        check("mt_hi", hi, 32'hA5A5A5A5);
        check("mt_lo", lo, 32'h5A5A5A5A);
        @(negedge clk);
        check("mt_done_clear", done, 0);

        issue(3'd3, 32'd100, 32'd7);
        repeat (9) @(negedge clk);
        flush = 1;
        @(negedge clk);
        flush = 0;
        check("flush_busy", busy, 0);
        check("flush_done_cycle_lo4", lo4, 14);
        check("flush_done_cycle_hi4", hi4, 2);
        watch(40);
        check("flush_no_done", nd, 0);
        check("flush_hi", hi, 32'hA5A5A5A5);
        check("flush_lo", lo, 32'h5A5A5A5A);

        @(negedge clk);
        start = 1; op = 3'd0; a = 2; b = 3; flush = 1;
        @(negedge clk);
        start = 0; flush = 0;
        check("sf_busy", busy, 0);
        watch(10);
        check("sf_no_done", nd, 0);
        check("sf_lo", lo, 32'h5A5A5A5A);

        issue(3'd6, 32'd1, 32'd1);
        check("rsv6_busy", busy, 0);
        issue(3'd7, 32'd1, 32'd1);
        check("rsv7_busy", busy, 0);
        watch(5);
        check("rsv_no_done", nd, 0);
        check("rsv_hi", hi, 32'hA5A5A5A5);

        issue(3'd3, 32'd100, 32'd7);
        repeat (4) @(negedge clk);
        reset = 1;
        #1;
        check("mrst_hi", hi, 0);
        check("mrst_lo", lo, 0);
        check("mrst_busy", busy, 0);
        @(negedge clk);
        reset = 0;
        watch(40);
        check("mrst_no_done", nd, 0);
        check("mrst_lo_after", lo, 0);
        check("mrst_hi_after", hi, 0);

        issue(3'd1, 32'd6, 32'd7);
        wait_done();
        check("post_rst_lo", lo, 42);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
